forwarding_hazard_unit: RTL and testbench

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

---
 rtl/forwarding_hazard_unit.sv | 130 +++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard detection for a 5-stage pipeline.
// Tracks EX/MEM/WB producers and selects operand bypasses one cycle ahead of EX.
module forwarding_hazard_unit #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_id_valid,
  input  logic [4:0]             i_id_rs,
  input  logic [4:0]             i_id_rt,
  input  logic                   i_id_uses_rs,
  input  logic                   i_id_uses_rt,
  input  logic [4:0]             i_id_write_register,
  input  logic                   i_id_reg_write,
  input  logic                   i_id_mem_read,
  input  logic                   i_flush,
  output logic [1:0]             o_forward_a,
  output logic [1:0]             o_forward_b,
  output logic                   o_stall,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] dest;
  } slot_t;

  localparam slot_t Bubble = '0;

  localparam logic [1:0] FwdRegFile = 2'b00;
  localparam logic [1:0] FwdMem     = 2'b01;
  localparam logic [1:0] FwdWb      = 2'b10;

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;

  logic [1:0]             fwd_a_q, fwd_a_d;
  logic [1:0]             fwd_b_q, fwd_b_d;
  logic [STALL_CNT_W-1:0] count_q, count_d;

  logic stall;
  logic bubble;

  // $0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.dest == r) && (r != 5'd0);
  endfunction

  // A load still in EX cannot supply data yet; that case is covered by the stall.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] r,
                                         input slot_t ex, input slot_t mem);
    logic [1:0] sel;
    sel = FwdRegFile;
    if (uses) begin
      if (slot_match(ex, r) && !ex.mem_read) begin
        sel = FwdMem;
      end else if (slot_match(mem, r)) begin
        sel = FwdWb;
      end
    end
    return sel;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (i_id_valid && !i_flush && ex_q.mem_read) begin
      stall = (i_id_uses_rs && slot_match(ex_q, i_id_rs)) ||
              (i_id_uses_rt && slot_match(ex_q, i_id_rt));
    end
  end

  assign bubble = stall || i_flush;

  always_comb begin
    ex_d    = Bubble;
    mem_d   = ex_q;
    wb_d    = mem_q;
    fwd_a_d = FwdRegFile;
    fwd_b_d = FwdRegFile;
    count_d = count_q;

    if (!bubble) begin
      ex_d.valid     = i_id_valid;
      ex_d.reg_write = i_id_reg_write;
      ex_d.mem_read  = i_id_mem_read;
      ex_d.dest      = i_id_write_register;
      if (i_id_valid) begin
        fwd_a_d = fwd_sel(i_id_uses_rs, i_id_rs, ex_q, mem_q);
        fwd_b_d = fwd_sel(i_id_uses_rt, i_id_rt, ex_q, mem_q);
      end
    end

    if (stall && (count_q != '1)) begin
      count_d = count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= Bubble;
      mem_q   <= Bubble;
      wb_q    <= Bubble;
      fwd_a_q <= FwdRegFile;
      fwd_b_q <= FwdRegFile;
      count_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      count_q <= count_d;
    end
  end

  assign o_forward_a   = fwd_a_q;
  assign o_forward_b   = fwd_b_q;
  assign o_stall       = stall;
  assign o_stall_count = count_q;

  // WB is kept only to mirror the real pipeline; it must trail MEM by exactly one cycle.
  wb_follows_mem: assert property (@(posedge clk) disable iff (!reset) wb_q == $past(mem_q));

  stall_excludes_flush: assert property (@(posedge clk) disable iff (!reset)
                                         !(o_stall && i_flush));

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit with hand-computed expectations.
module tb_forwarding_hazard_unit;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            reset;
  logic            i_id_valid;
  logic [4:0]      i_id_rs;
  logic [4:0]      i_id_rt;
  logic            i_id_uses_rs;
  logic            i_id_uses_rt;
  logic [4:0]      i_id_write_register;
  logic            i_id_reg_write;
  logic            i_id_mem_read;
  logic            i_flush;
  logic [1:0]      o_forward_a;
  logic [1:0]      o_forward_b;
  logic            o_stall;
  logic [CntW-1:0] o_stall_count;

  int unsigned n_checks;
  int unsigned n_errors;
  logic        stall_seen;

  forwarding_hazard_unit #(
    .STALL_CNT_W(CntW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_id_valid         (i_id_valid),
    .i_id_rs            (i_id_rs),
    .i_id_rt            (i_id_rt),
    .i_id_uses_rs       (i_id_uses_rs),
    .i_id_uses_rt       (i_id_uses_rt),
    .i_id_write_register(i_id_write_register),
    .i_id_reg_write     (i_id_reg_write),
    .i_id_mem_read      (i_id_mem_read),
    .i_flush            (i_flush),
    .o_forward_a        (o_forward_a),
    .o_forward_b        (o_forward_b),
    .o_stall            (o_stall),
    .o_stall_count      (o_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Presents one ID instruction, samples o_stall before the edge, then clocks it in.
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic fl);
    i_id_valid          = v;
    i_id_rs             = rs;
    i_id_rt             = rt;
    i_id_uses_rs        = urs;
    i_id_uses_rt        = urt;
    i_id_write_register = wr;
    i_id_reg_write      = rw;
    i_id_mem_read       = mr;
    i_flush             = fl;
    #1;
    stall_seen = o_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    issue(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [4:0] base, input logic [4:0] dst);
    issue(1'b1, base, dst, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic nop();
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_inputs();
    i_id_valid          = 1'b0;
    i_id_rs             = '0;
    i_id_rt             = '0;
    i_id_uses_rs        = 1'b0;
    i_id_uses_rt        = 1'b0;
    i_id_write_register = '0;
    i_id_reg_write      = 1'b0;
    i_id_mem_read       = 1'b0;
    i_flush             = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset();
    check_eq("reset_fwd_a", 32'(o_forward_a), 32'd0);
    check_eq("reset_fwd_b", 32'(o_forward_b), 32'd0);
    check_eq("reset_stall", 32'(o_stall), 32'd0);
    check_eq("reset_count", 32'(o_stall_count), 32'd0);

    // add $3,$1,$2 ; sub $4,$3,$5
    alu(5'd1, 5'd2, 5'd3);
    check_eq("add_stall", 32'(stall_seen), 32'd0);
    check_eq("add_fwd_a", 32'(o_forward_a), 32'd0);
    alu(5'd3, 5'd5, 5'd4);
    check_eq("sub_stall", 32'(stall_seen), 32'd0);
    check_eq("sub_fwd_a", 32'(o_forward_a), 32'b01);
    check_eq("sub_fwd_b", 32'(o_forward_b), 32'b00);

    // add $3 ; nop ; or $6,$5,$3
    alu(5'd1, 5'd2, 5'd3);
    nop();
    alu(5'd5, 5'd3, 5'd6);
    check_eq("or_fwd_a", 32'(o_forward_a), 32'b00);
    check_eq("or_fwd_b", 32'(o_forward_b), 32'b10);

    // add $3 ; sub $3 ; and $7,$3,$3 -> nearer producer wins
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd3, 5'd3, 5'd7);
    check_eq("and_fwd_a", 32'(o_forward_a), 32'b01);
    check_eq("and_fwd_b", 32'(o_forward_b), 32'b01);

    // Matching rs that is not read must not forward
    alu(5'd1, 5'd2, 5'd9);
    issue(1'b1, 5'd9, 5'd9, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    check_eq("unused_rs_fwd_a", 32'(o_forward_a), 32'b00);
    check_eq("unused_rs_fwd_b", 32'(o_forward_b), 32'b01);

    // lw $2,0($1) ; add $4,$2,$2
    load(5'd1, 5'd2);
    alu(5'd2, 5'd2, 5'd4);
    check_eq("lu_stall", 32'(stall_seen), 32'd1);
    check_eq("lu_bubble_a", 32'(o_forward_a), 32'b00);
    check_eq("lu_bubble_b", 32'(o_forward_b), 32'b00);
    alu(5'd2, 5'd2, 5'd4);
    check_eq("lu_single_stall", 32'(stall_seen), 32'd0);
    check_eq("lu_fwd_a", 32'(o_forward_a), 32'b10);
    check_eq("lu_fwd_b", 32'(o_forward_b), 32'b10);
    check_eq("lu_count", 32'(o_stall_count), 32'd1);

    // addi $0,$1,5 ; add $4,$0,$0
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    alu(5'd0, 5'd0, 5'd4);
    check_eq("r0_stall", 32'(stall_seen), 32'd0);
    check_eq("r0_fwd_a", 32'(o_forward_a), 32'b00);
    check_eq("r0_fwd_b", 32'(o_forward_b), 32'b00);

    // lw $2 ; flushed add $4,$2,$2
    load(5'd1, 5'd2);
    issue(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    check_eq("flush_stall", 32'(stall_seen), 32'd0);
    check_eq("flush_count", 32'(o_stall_count), 32'd1);
    check_eq("flush_fwd_a", 32'(o_forward_a), 32'b00);

    // Distance 3 is served by the register file
    alu(5'd1, 5'd2, 5'd8);
    nop();
    nop();
    alu(5'd8, 5'd8, 5'd11);
    check_eq("dist3_fwd_a", 32'(o_forward_a), 32'b00);
    check_eq("dist3_fwd_b", 32'(o_forward_b), 32'b00);

    // 19 load-use stalls saturate a 4-bit counter
    do_reset();
    for (int i = 0; i < 19; i++) begin
      load(5'd1, 5'd2);
      alu(5'd2, 5'd3, 5'd4);
      if (stall_seen !== 1'b1) check_eq("sat_stall", 32'(stall_seen), 32'd1);
      alu(5'd2, 5'd3, 5'd4);
      if (i == 13) check_eq("sat_count_14", 32'(o_stall_count), 32'd14);
    end
    check_eq("sat_count", 32'(o_stall_count), 32'hF);

    // Reset mid-stall clears everything without a clock edge
    do_reset();
    load(5'd1, 5'd2);
    i_id_valid          = 1'b1;
    i_id_rs             = 5'd2;
    i_id_rt             = 5'd2;
    i_id_uses_rs        = 1'b1;
    i_id_uses_rt        = 1'b1;
    i_id_write_register = 5'd4;
    i_id_reg_write      = 1'b1;
    i_id_mem_read       = 1'b0;
    i_flush             = 1'b0;
    #1;
    check_eq("pre_rst_stall", 32'(o_stall), 32'd1);
    check_eq("pre_rst_count", 32'(o_stall_count), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check_eq("async_rst_stall", 32'(o_stall), 32'd0);
    check_eq("async_rst_fwd_a", 32'(o_forward_a), 32'd0);
    check_eq("async_rst_fwd_b", 32'(o_forward_b), 32'd0);
    check_eq("async_rst_count", 32'(o_stall_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    alu(5'd5, 5'd6, 5'd7);
    check_eq("post_rst_stall", 32'(stall_seen), 32'd0);
    check_eq("post_rst_fwd_a", 32'(o_forward_a), 32'b00);
    check_eq("post_rst_fwd_b", 32'(o_forward_b), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
